bus_initiator: RTL and testbench
================================

# bus_initiator

Single-outstanding-transfer Wishbone B4 pipelined bus master. Accepts one read or write command on a valid/ready request port and drives the shared bus. It works against any of our memory-mapped peripherals, e.g. the LED register block. It returns read data and error status on a valid/ready response port. It is the front end that CPU-side and debug-side logic use to reach peripheral registers.

## Interface

**Parameters**
- DataWidth, 32, bus data width; fixed by package constant.
- AddrWidth, 32, bus address width; fixed by package constant.
- SelWidth, DataWidth/8, byte-select width.
- TimeoutCycles, 255, cycles without ack/err before abort; used only with the timeout feature.

**Ports**
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  system clock.
  - reset_n  in  1  asynchronous active-low reset.
- Request port:
  - req_valid  in  1  command present.
  - req_ready  out  1  command accepted when both high.
  - req_addr  in  AddrWidth  target address.
  - req_wdata  in  DataWidth  write data.
  - req_sel  in  SelWidth  byte enables.
  - req_we  in  1  1 = write, 0 = read.
- Response port:
  - rsp_valid  out  1  response present.
  - rsp_ready  in  1  response consumed when both high.
  - rsp_rdata  out  DataWidth  data captured on ack.
  - rsp_err  out  1  transfer ended in bus_err or timeout.
- Wishbone master side:
  - bus_data_m  out  DataWidth  write data.
  - bus_addr  out  AddrWidth  address.
  - bus_sel  out  SelWidth  byte select.
  - bus_cyc  out  1  cycle.
  - bus_stb  out  1  strobe.
  - bus_we  out  1  write enable.
  - bus_data_s  in  DataWidth  read data.
  - bus_ack  in  1  acknowledge.
  - bus_stall  in  1  stall.
  - bus_err  in  1  error.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - req_ready = 1; all other outputs are held low or zero.
  - On req_valid: register addr/wdata/sel/we onto the bus outputs, set bus_cyc = bus_stb = 1, go to REQ.
- **REQ** (stb asserted)
  - bus_stall = 1: hold stb and all bus outputs unchanged.
  - bus_stall = 0: the request is taken this edge; clear stb.
    - If bus_ack or bus_err is also high this edge, go to RESP.
    - Otherwise go to WAIT.
  - bus_ack/bus_err sampled while bus_stall = 1 are ignored.
- **WAIT** (cyc = 1, stb = 0)
  - On bus_ack or bus_err: clear cyc, capture the response, go to RESP.
- **Response capture**
  - On ack: rsp_rdata = bus_data_s for both reads and writes.
  - bus_err has priority: if err and ack are both high, rsp_err = 1 and rsp_rdata = 0.
- **RESP**
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready: clear rsp_valid, go to IDLE.
- req_ready is high only in IDLE; exactly one transfer is outstanding at any time.
- **Reset values**: bus_cyc, bus_stb, bus_we = 0; bus_addr, bus_data_m, bus_sel = 0; rsp_valid = 0; rsp_err = 0; rsp_rdata = 0; FSM in IDLE, so req_ready = 1.
- **Reset mid-transfer**: bus_cyc and bus_stb drop asynchronously and the transfer is abandoned. No response is produced.

## Timing
- Every output except req_ready is registered; req_ready decodes the state directly.
- Reference latency (stall = 0, ack one cycle after stb):
  - request handshake at edge N;
  - stb/cyc high in cycle N+1;
  - ack in cycle N+2;
  - rsp_valid high from N+3;
  - cyc low from N+3.
- Minimum turnaround (ack with the stall-free strobe): rsp_valid in the cycle after the stb cycle.
- req_ready is high again in the cycle after the response handshake. The back-to-back command rate is therefore one per 4 cycles with a one-cycle-ack slave.

## Configuration
- Macro: BUS_INITIATOR_TIMEOUT_EN.
- **Defined**
  - A cycle counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When it reaches TimeoutCycles with no ack/err: drop cyc and stb, set rsp_err = 1 and rsp_rdata = 0, go to RESP.
  - If ack/err arrives in the same cycle the limit is reached, the real response wins.
- **Undefined**
  - No counter is instantiated; the FSM waits in REQ/WAIT indefinitely.
  - TimeoutCycles is unused.

## Structure
- Shared package bus_pkg holds:
  - DataWidth, AddrWidth, SelWidth constants;
  - bus_initiator_state_t enum (IDLE, REQ, WAIT, RESP);
  - a request struct typedef (addr, wdata, sel, we).
- One sub-module, bus_timeout_counter: clear/enable in, expired out, width $clog2(TimeoutCycles+1). It is instantiated only under BUS_INITIATOR_TIMEOUT_EN.

## Test plan
- **Write**: req addr 0x0, wdata 0x5, sel 0x1, we 1, single-cycle-ack slave → bus_cyc/bus_stb/bus_we in cycle N+1 with bus_data_m 0x5; rsp_valid at N+3 with rsp_err 0.
- **Read**: slave returns 0x0000_000A → rsp_rdata 0x0000_000A, rsp_err 0; bus_cyc low when rsp_valid rises.
- **Stall**: stall held 3 cycles → bus_stb high for 4 cycles with bus_addr/bus_data_m/bus_sel/bus_we constant; stb drops after the first stall-free cycle; one response only.
- **Error**: bus_err and bus_ack together → rsp_err 1, rsp_rdata 0; rsp_valid held 5 cycles with rsp_ready low, then cleared on handshake; req_ready returns the next cycle.
- **Timeout (macro defined, TimeoutCycles 8)**: slave never responds → cyc drops and rsp_valid rises with rsp_err 1. With the macro undefined, cyc stays high for 100+ cycles.
- **Reset mid-transfer**: assert reset_n low during WAIT → bus_cyc/bus_stb go low without waiting for a clock edge; after release: req_ready 1, rsp_valid 0.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared widths, FSM state enum and request struct for bus_initiator
package bus_pkg;

  localparam int DataWidth = 32;
  localparam int AddrWidth = 32;
  localparam int SelWidth  = DataWidth / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } bus_initiator_state_t;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic [SelWidth-1:0]  sel;
    logic                 we;
  } bus_req_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// rtl/bus_timeout_counter.sv - saturating cycle counter, only used when BUS_INITIATOR_TIMEOUT_EN is defined
module bus_timeout_counter #(
  parameter int TimeoutCycles = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int                  CntWidth = $clog2(TimeoutCycles + 1);
  localparam logic [CntWidth-1:0] Limit    = CntWidth'(TimeoutCycles);

  logic [CntWidth-1:0] cnt_q;
  logic [CntWidth-1:0] cnt_d;

  // Restart on clear, otherwise count enabled cycles and stick at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != Limit)) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == Limit);

endmodule

// File: rtl/bus_initiator.sv
// rtl/bus_initiator.sv - single-outstanding Wishbone B4 pipelined master; optional timeout via BUS_INITIATOR_TIMEOUT_EN
module bus_initiator
  import bus_pkg::*;
#(
  parameter int TimeoutCycles = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  // request port
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [AddrWidth-1:0] req_addr,
  input  logic [DataWidth-1:0] req_wdata,
  input  logic [SelWidth-1:0]  req_sel,
  input  logic                 req_we,
  // response port
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  // wishbone master side
  output logic [DataWidth-1:0] bus_data_m,
  output logic [AddrWidth-1:0] bus_addr,
  output logic [SelWidth-1:0]  bus_sel,
  output logic                 bus_cyc,
  output logic                 bus_stb,
  output logic                 bus_we,
  input  logic [DataWidth-1:0] bus_data_s,
  input  logic                 bus_ack,
  input  logic                 bus_stall,
  input  logic                 bus_err
);

  bus_initiator_state_t state_q, state_d;
  bus_req_t             req_q, req_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;

  // Transfer termination causes, decoded alongside the next-state logic.
  logic end_bus;
  logic end_tmo;
  logic tmo_expired;

`ifdef BUS_INITIATOR_TIMEOUT_EN
  logic tmo_clear;
  logic tmo_enable;

  assign tmo_clear  = (state_q == IDLE) && req_valid;
  assign tmo_enable = (state_q == REQ) || (state_q == WAIT);

  bus_timeout_counter #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (reset_n),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );
`else
  // No counter in this build; the comparison only ties off the parameter and is always false.
  assign tmo_expired = (TimeoutCycles < 0);
`endif

  // Next-state and registered-output logic for the four-state transfer FSM.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    end_bus     = 1'b0;
    end_tmo     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d.addr  = req_addr;
          req_d.wdata = req_wdata;
          req_d.sel   = req_sel;
          req_d.we    = req_we;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        // A stalled strobe is not accepted, so ack/err seen with it cannot belong to us.
        if (!bus_stall) begin
          stb_d   = 1'b0;
          state_d = WAIT;
        end
        if (!bus_stall && (bus_ack || bus_err)) begin
          end_bus = 1'b1;
        end else if (tmo_expired) begin
          end_tmo = 1'b1;
        end
      end
      WAIT: begin
        if (bus_ack || bus_err) begin
          end_bus = 1'b1;
        end else if (tmo_expired) begin
          end_tmo = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Close the cycle and latch the response; err (or timeout) beats ack and zeroes the data.
    if (end_bus || end_tmo) begin
      cyc_d       = 1'b0;
      stb_d       = 1'b0;
      req_d       = '0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = end_tmo || bus_err;
      rsp_rdata_d = (end_tmo || bus_err) ? '0 : bus_data_s;
      state_d     = RESP;
    end
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign bus_addr   = req_q.addr;
  assign bus_data_m = req_q.wdata;
  assign bus_sel    = req_q.sel;
  assign bus_we     = req_q.we;
  assign bus_cyc    = cyc_q;
  assign bus_stb    = stb_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;

endmodule

// File: tb/tb_bus_initiator.sv
// tb/tb_bus_initiator.sv - directed scoreboard bench for bus_initiator
module tb_bus_initiator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_sel;
  logic        req_we;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] bus_data_m;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic        bus_cyc;
  logic        bus_stb;
  logic        bus_we;
  logic [31:0] bus_data_s;
  logic        bus_ack;
  logic        bus_stall;
  logic        bus_err;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bus_initiator #(
    .TimeoutCycles(8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_sel   (req_sel),
    .req_we    (req_we),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .bus_data_m(bus_data_m),
    .bus_addr  (bus_addr),
    .bus_sel   (bus_sel),
    .bus_cyc   (bus_cyc),
    .bus_stb   (bus_stb),
    .bus_we    (bus_we),
    .bus_data_s(bus_data_s),
    .bus_ack   (bus_ack),
    .bus_stall (bus_stall),
    .bus_err   (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for a single edge and check the bus in the following cycle.
  task automatic drive_req(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] sel, input logic we);
    req_addr  = addr;
    req_wdata = wdata;
    req_sel   = sel;
    req_we    = we;
    req_valid = 1'b1;
    check({tag, "_req_ready"}, req_ready, 1);
    tick();
    req_valid = 1'b0;
    check({tag, "_cyc"}, bus_cyc, 1);
    check({tag, "_stb"}, bus_stb, 1);
    check({tag, "_addr"}, bus_addr, addr);
    check({tag, "_data_m"}, bus_data_m, wdata);
    check({tag, "_sel"}, bus_sel, sel);
    check({tag, "_we"}, bus_we, we);
    check({tag, "_req_ready_busy"}, req_ready, 0);
  endtask

  task automatic push_rsp(input logic [31:0] rdata, input logic err);
    rsp_t e;
    e.rdata = rdata;
    e.err   = err;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    rsp_t e;
    tests++;
    assert (sb_q.size() != 0) else begin
      fails++;
      $error("FAIL %s_sb_empty: observed 0 entries expected 1", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_rsp_valid"}, rsp_valid, 1);
      check({tag, "_rsp_rdata"}, rsp_rdata, e.rdata);
      check({tag, "_rsp_err"}, rsp_err, e.err);
    end
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_rsp_valid_clr"}, rsp_valid, 0);
    check({tag, "_req_ready_back"}, req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_sel    = '0;
    req_we     = 1'b0;
    rsp_ready  = 1'b0;
    bus_data_s = '0;
    bus_ack    = 1'b0;
    bus_stall  = 1'b0;
    bus_err    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_cyc", bus_cyc, 0);
    check("rst_stb", bus_stb, 0);
    check("rst_we", bus_we, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_data_m", bus_data_m, 0);
    check("rst_sel", bus_sel, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Write with a one-cycle-ack slave: ack in N+2, response from N+3.
    drive_req("wr", 32'h0, 32'h5, 4'h1, 1'b1);
    push_rsp(32'h1234, 1'b0);
    tick();
    check("wr_stb_drop", bus_stb, 0);
    check("wr_cyc_wait", bus_cyc, 1);
    check("wr_rsp_early", rsp_valid, 0);
    bus_ack    = 1'b1;
    bus_data_s = 32'h1234;
    tick();
    bus_ack    = 1'b0;
    bus_data_s = '0;
    check("wr_cyc_end", bus_cyc, 0);
    pop_check("wr");
    handshake("wr");

    // Read.
    drive_req("rd", 32'h10, 32'h0, 4'hF, 1'b0);
    push_rsp(32'h0000_000A, 1'b0);
    tick();
    bus_ack    = 1'b1;
    bus_data_s = 32'h0000_000A;
    tick();
    bus_ack    = 1'b0;
    bus_data_s = '0;
    check("rd_cyc_low_at_rsp", bus_cyc, 0);
    pop_check("rd");
    handshake("rd");

    // Stall for three cycles, with a stray ack during the stall that must be ignored.
    bus_stall = 1'b1;
    drive_req("st", 32'h20, 32'hDEAD_BEEF, 4'h3, 1'b1);
    push_rsp(32'h55, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("st_stb_held", bus_stb, 1);
      check("st_addr_held", bus_addr, 32'h20);
      check("st_data_held", bus_data_m, 32'hDEAD_BEEF);
      check("st_sel_held", bus_sel, 4'h3);
      check("st_we_held", bus_we, 1);
      bus_ack = (i == 1);
      tick();
    end
    bus_ack   = 1'b0;
    bus_stall = 1'b0;
    check("st_stb_4th", bus_stb, 1);
    check("st_ack_ignored", rsp_valid, 0);
    tick();
    check("st_stb_drop", bus_stb, 0);
    check("st_cyc_wait", bus_cyc, 1);
    bus_ack    = 1'b1;
    bus_data_s = 32'h55;
    tick();
    bus_ack    = 1'b0;
    bus_data_s = '0;
    pop_check("st");
    handshake("st");
    tick();
    check("st_single_rsp", rsp_valid, 0);

    // Error together with ack on the stall-free strobe: minimum turnaround, err wins.
    drive_req("er", 32'h30, 32'h0, 4'hF, 1'b0);
    push_rsp(32'h0, 1'b1);
    bus_err    = 1'b1;
    bus_ack    = 1'b1;
    bus_data_s = 32'hFFFF_FFFF;
    tick();
    bus_err    = 1'b0;
    bus_ack    = 1'b0;
    bus_data_s = '0;
    pop_check("er");
    check("er_cyc", bus_cyc, 0);
    check("er_stb", bus_stb, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("er_valid_hold", rsp_valid, 1);
      check("er_err_hold", rsp_err, 1);
      check("er_rdata_hold", rsp_rdata, 0);
    end
    handshake("er");

    // Silent slave.
    drive_req("to", 32'h40, 32'h0, 4'hF, 1'b0);
`ifdef BUS_INITIATOR_TIMEOUT_EN
    begin
      int n;
      n = 0;
      push_rsp(32'h0, 1'b1);
      while (!rsp_valid && n < 50) begin
        tick();
        n++;
      end
      check("to_within_bound", (n < 50), 1);
      check("to_cyc", bus_cyc, 0);
      check("to_stb", bus_stb, 0);
      pop_check("to");
      handshake("to");
    end
`else
    begin
      logic dropped;
      dropped = 1'b0;
      repeat (120) begin
        tick();
        if (!bus_cyc || rsp_valid) dropped = 1'b1;
      end
      check("to_cyc_held", dropped, 0);
    end
`endif

    // Reset in WAIT: cyc/stb fall without a clock edge, no response afterwards.
    if (req_ready) begin
      drive_req("rs", 32'h50, 32'h0, 4'hF, 1'b0);
      tick();
    end
    check("rs_cyc_wait", bus_cyc, 1);
    check("rs_stb_wait", bus_stb, 0);
    #3;
    reset_n = 1'b0;
    #1;
    check("rs_cyc_async", bus_cyc, 0);
    check("rs_stb_async", bus_stb, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("rs_req_ready", req_ready, 1);
    check("rs_rsp_valid", rsp_valid, 0);

    // Normal operation resumes after the reset.
    drive_req("rc", 32'h60, 32'h0, 4'hF, 1'b0);
    push_rsp(32'h77, 1'b0);
    tick();
    bus_ack    = 1'b1;
    bus_data_s = 32'h77;
    tick();
    bus_ack    = 1'b0;
    bus_data_s = '0;
    pop_check("rc");
    handshake("rc");

    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
